// File: rtl/wb_single_master_if.sv
// Wishbone B3 classic bus bundle between a single master and its interconnect port.
// Members keep the master-side Wishbone names so the master's port list reads like the bus.
interface wb_single_master_if;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        wb_rty_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
        input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
        output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );
endinterface

// File: rtl/wb_single_master.sv
// Single-beat Wishbone B3 classic master: one command in, one bus transfer out,
// with retry on rty, bus watchdog, and a one-cycle done/error completion pulse.
module wb_single_master #(
    parameter int TIMEOUT   = 64,
    parameter int MAX_RETRY = 4
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic        start,
    input  logic [31:0] address,
    input  logic [3:0]  selection,
    input  logic        write,
    input  logic [31:0] data_wr,
    output logic [31:0] data_rd,
    output logic        active,
    output logic        done,
    output logic        error,
    wb_single_master_if.master wb
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [1:0] {IDLE, BUS, RETRY, DONE} state_t;

    state_t        state_q, state_d;
    logic [31:0]   cmd_adr_q, cmd_adr_d;
    logic [31:0]   cmd_dat_q, cmd_dat_d;
    logic [3:0]    cmd_sel_q, cmd_sel_d;
    logic          cmd_we_q, cmd_we_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [RW-1:0] rty_q, rty_d;
    logic [31:0]   data_rd_q, data_rd_d;
    logic          active_q, active_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          cyc_q, cyc_d;
    logic          stb_q, stb_d;
    logic          we_q, we_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic [3:0]    sel_q, sel_d;
    logic          in_bus_d;

    always_comb begin
        state_d   = state_q;
        cmd_adr_d = cmd_adr_q;
        cmd_dat_d = cmd_dat_q;
        cmd_sel_d = cmd_sel_q;
        cmd_we_d  = cmd_we_q;
        tmo_d     = tmo_q;
        rty_d     = rty_q;
        data_rd_d = data_rd_q;
        error_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cmd_adr_d = address;
                    cmd_dat_d = data_wr;
                    cmd_sel_d = selection;
                    cmd_we_d  = write;
                    tmo_d     = '0;
                    rty_d     = '0;
                    state_d   = BUS;
                end
            end
            BUS: begin
                // Responses count only while our strobe is actually on the bus.
                if (stb_q) begin
                    if (wb.wb_err_i) begin
                        error_d = 1'b1;
                        state_d = DONE;
                    end else if (wb.wb_ack_i) begin
                        if (!cmd_we_q) begin
                            data_rd_d = wb.wb_dat_i;
                        end
                        state_d = DONE;
                    end else if (wb.wb_rty_i) begin
                        if (int'(rty_q) < MAX_RETRY) begin
                            rty_d   = rty_q + 1'b1;
                            state_d = RETRY;
                        end else begin
                            error_d = 1'b1;
                            state_d = DONE;
                        end
                    end else if ((TIMEOUT != 0) && (int'(tmo_q) == TIMEOUT - 1)) begin
                        error_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end
            RETRY: begin
                tmo_d   = '0;
                state_d = BUS;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are computed from the next state so every port comes straight from a flop.
        in_bus_d = (state_d == BUS);
        active_d = (state_d != IDLE);
        done_d   = (state_d == DONE);
        cyc_d    = in_bus_d;
        stb_d    = in_bus_d;
        we_d     = in_bus_d && cmd_we_d;
        adr_d    = in_bus_d ? cmd_adr_d : 32'h0;
        sel_d    = in_bus_d ? cmd_sel_d : 4'h0;
        dat_d    = (in_bus_d && cmd_we_d) ? cmd_dat_d : 32'h0;
    end

    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            state_q   <= IDLE;
            tmo_q     <= '0;
            rty_q     <= '0;
            data_rd_q <= 32'h0;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= 32'h0;
            dat_q     <= 32'h0;
            sel_q     <= 4'h0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            rty_q     <= rty_d;
            data_rd_q <= data_rd_d;
            active_q  <= active_d;
            done_q    <= done_d;
            error_q   <= error_d;
            cyc_q     <= cyc_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
        end
    end

    // Captured command is only consumed in BUS, which is always entered through a capture.
    always_ff @(posedge wb_clk) begin
        cmd_adr_q <= cmd_adr_d;
        cmd_dat_q <= cmd_dat_d;
        cmd_sel_q <= cmd_sel_d;
        cmd_we_q  <= cmd_we_d;
    end

    assign data_rd     = data_rd_q;
    assign active      = active_q;
    assign done        = done_q;
    assign error       = error_q;
    assign wb.wb_adr_o = adr_q;
    assign wb.wb_dat_o = dat_q;
    assign wb.wb_sel_o = sel_q;
    assign wb.wb_we_o  = we_q;
    assign wb.wb_cyc_o = cyc_q;
    assign wb.wb_stb_o = stb_q;
    assign wb.wb_cti_o = 3'b000;
    assign wb.wb_bte_o = 2'b00;

endmodule

// File: tb/tb_wb_single_master.sv
// Directed bench for wb_single_master: table of single transfers against a small
// scripted Wishbone slave, plus hand sequences for level start, ignored start and reset.
module tb_wb_single_master;

    localparam logic [2:0] R_NONE = 3'd0, R_ACK = 3'd1, R_ERR = 3'd2, R_RTY = 3'd3,
                           R_ALL = 3'd4, R_ACKRTY = 3'd5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] address;
    logic [3:0]  selection;
    logic        write;
    logic [31:0] data_wr;
    logic [31:0] data_rd;
    logic        active, done, error;
    logic [2:0]  cur_resp;
    logic [31:0] mem [0:15];

    int n_cmp  = 0;
    int n_fail = 0;

    wb_single_master_if bus ();

    wb_single_master #(.TIMEOUT(64), .MAX_RETRY(4)) dut (
        .wb_clk    (clk),
        .wb_rst    (rst_n),
        .start     (start),
        .address   (address),
        .selection (selection),
        .write     (write),
        .data_wr   (data_wr),
        .data_rd   (data_rd),
        .active    (active),
        .done      (done),
        .error     (error),
        .wb        (bus.master)
    );

    always #5 clk = ~clk;

    // Scripted slave: response chosen by the test, only while strobed.
    always_comb begin
        bus.wb_ack_i = bus.wb_stb_o && (cur_resp == R_ACK || cur_resp == R_ALL || cur_resp == R_ACKRTY);
        bus.wb_err_i = bus.wb_stb_o && (cur_resp == R_ERR || cur_resp == R_ALL);
        bus.wb_rty_i = bus.wb_stb_o && (cur_resp == R_RTY || cur_resp == R_ALL || cur_resp == R_ACKRTY);
        bus.wb_dat_i = bus.wb_we_o ? 32'hBADD_A7A0 : mem[bus.wb_adr_o[5:2]];
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
        end else if (bus.wb_stb_o && bus.wb_we_o && bus.wb_ack_i && !bus.wb_err_i) begin
            for (int b = 0; b < 4; b++)
                if (bus.wb_sel_o[b])
                    mem[bus.wb_adr_o[5:2]][8*b +: 8] <= bus.wb_dat_o[8*b +: 8];
        end
    end

    typedef struct {
        logic             wr;
        logic [31:0]      adr;
        logic [3:0]       sel;
        logic [31:0]      wdat;
        logic [5:0][2:0]  resp;
        bit               pulse;
        logic             exp_err;
        logic [31:0]      exp_drd;
        int               exp_lat;
        int               exp_phases;
        int               exp_stbc;
    } vec_t;

    vec_t vecs [16];
    int   nvec = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic wr, input logic [31:0] adr, input logic [3:0] sel,
                       input logic [31:0] wdat, input logic [2:0] r0, input logic [2:0] r1,
                       input logic [2:0] r2, input logic [2:0] r3, input logic [2:0] r4,
                       input bit pulse, input logic err, input logic [31:0] drd,
                       input int lat, input int ph, input int sc);
        vecs[nvec].wr         = wr;
        vecs[nvec].adr        = adr;
        vecs[nvec].sel        = sel;
        vecs[nvec].wdat       = wdat;
        vecs[nvec].resp       = {R_NONE, r4, r3, r2, r1, r0};
        vecs[nvec].pulse      = pulse;
        vecs[nvec].exp_err    = err;
        vecs[nvec].exp_drd    = drd;
        vecs[nvec].exp_lat    = lat;
        vecs[nvec].exp_phases = ph;
        vecs[nvec].exp_stbc   = sc;
        nvec++;
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        int k = 0, lat = 0, phases = 0, stbc = 0;
        bit prev_stb = 0, seen = 0, first = 1, act_ok = 1;
        logic [31:0] f_adr = 0, f_dat = 0;
        logic [3:0]  f_sel = 0;
        logic        f_we = 0, f_cyc = 0;
        logic [4:0]  f_cb = 0;
        string       tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        address   = v.adr;
        selection = v.sel;
        write     = v.wr;
        data_wr   = v.wdat;
        start     = 1'b1;
        cur_resp  = v.resp[0];
        while (!seen && lat < 200) begin
            @(negedge clk);
            lat++;
            if (lat == 1) start = 1'b0;
            if (v.pulse && lat == 2) start = 1'b1;
            if (v.pulse && lat == 3) start = 1'b0;
            if (prev_stb && v.resp[k] != R_NONE && k < 5) k++;
            if (!active) act_ok = 0;
            if (bus.wb_stb_o) begin
                stbc++;
                if (!prev_stb) phases++;
                if (first) begin
                    f_adr = bus.wb_adr_o; f_dat = bus.wb_dat_o; f_sel = bus.wb_sel_o;
                    f_we = bus.wb_we_o; f_cyc = bus.wb_cyc_o;
                    f_cb = {bus.wb_cti_o, bus.wb_bte_o};
                    first = 0;
                end
            end
            prev_stb = bus.wb_stb_o;
            cur_resp = v.resp[k];
            if (done) seen = 1;
        end
        start = 1'b0;
        chk({tag, " done_seen"}, 32'(seen), 32'd1);
        chk({tag, " latency"}, 32'(lat - 1), 32'(v.exp_lat));
        chk({tag, " phases"}, 32'(phases), 32'(v.exp_phases));
        chk({tag, " stb_cycles"}, 32'(stbc), 32'(v.exp_stbc));
        chk({tag, " error"}, 32'(error), 32'(v.exp_err));
        chk({tag, " data_rd"}, data_rd, v.exp_drd);
        chk({tag, " active_held"}, 32'(act_ok), 32'd1);
        chk({tag, " adr_o"}, f_adr, v.adr);
        chk({tag, " we_o"}, 32'(f_we), 32'(v.wr));
        chk({tag, " dat_o"}, f_dat, v.wr ? v.wdat : 32'h0);
        chk({tag, " sel_o"}, 32'(f_sel), 32'(v.sel));
        chk({tag, " cyc_o"}, 32'(f_cyc), 32'd1);
        chk({tag, " cti_bte"}, 32'(f_cb), 32'd0);
        @(negedge clk);
        cur_resp = R_NONE;
        chk({tag, " done_after"}, 32'(done), 32'd0);
        chk({tag, " active_after"}, 32'(active), 32'd0);
        if (v.pulse) begin
            int extra = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (bus.wb_cyc_o || active) extra++;
            end
            chk({tag, " no_second_txn"}, 32'(extra), 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; address = 32'h0; selection = 4'h0;
        write = 1'b0; data_wr = 32'h0; cur_resp = R_NONE;

        //   wr adr           sel   wdat          r0        r1     r2     r3     r4    p  err drd           lat ph sc
        add(1, 32'h9000_0000, 4'hF, 32'hDEAD_BEEF, R_ACK,    R_NONE, R_NONE, R_NONE, R_NONE, 0, 0, 32'h0000_0000, 1, 1, 1);
        add(0, 32'h9000_0000, 4'hF, 32'h0,         R_ACK,    R_NONE, R_NONE, R_NONE, R_NONE, 0, 0, 32'hDEAD_BEEF, 1, 1, 1);
        add(1, 32'h9000_0004, 4'h3, 32'h1234_5678, R_ACK,    R_NONE, R_NONE, R_NONE, R_NONE, 0, 0, 32'hDEAD_BEEF, 1, 1, 1);
        add(0, 32'h9000_0004, 4'hF, 32'h0,         R_ACK,    R_NONE, R_NONE, R_NONE, R_NONE, 0, 0, 32'h0000_5678, 1, 1, 1);
        add(0, 32'h9000_0000, 4'hF, 32'h0,         R_ERR,    R_NONE, R_NONE, R_NONE, R_NONE, 0, 1, 32'h0000_5678, 1, 1, 1);
        add(0, 32'h9000_0000, 4'hF, 32'h0,         R_RTY,    R_RTY,  R_ACK,  R_NONE, R_NONE, 0, 0, 32'hDEAD_BEEF, 5, 3, 3);
        add(1, 32'h9000_0008, 4'hF, 32'hCAFE_F00D, R_RTY,    R_RTY,  R_RTY,  R_RTY,  R_RTY,  0, 1, 32'hDEAD_BEEF, 9, 5, 5);
        add(0, 32'h9000_0008, 4'hF, 32'h0,         R_ACK,    R_NONE, R_NONE, R_NONE, R_NONE, 0, 0, 32'h0000_0000, 1, 1, 1);
        add(0, 32'h9000_000C, 4'hF, 32'h0,         R_NONE,   R_NONE, R_NONE, R_NONE, R_NONE, 0, 1, 32'h0000_0000, 64, 1, 64);
        add(1, 32'h9000_000C, 4'hF, 32'h1111_2222, R_ALL,    R_NONE, R_NONE, R_NONE, R_NONE, 0, 1, 32'h0000_0000, 1, 1, 1);
        add(0, 32'h9000_0000, 4'hF, 32'h0,         R_ACKRTY, R_NONE, R_NONE, R_NONE, R_NONE, 0, 0, 32'hDEAD_BEEF, 1, 1, 1);
        add(0, 32'h9000_000C, 4'h1, 32'h0,         R_ACK,    R_NONE, R_NONE, R_NONE, R_NONE, 0, 0, 32'h0000_0000, 1, 1, 1);
        add(0, 32'h9000_0004, 4'hF, 32'h0,         R_RTY,    R_RTY,  R_ACK,  R_NONE, R_NONE, 1, 0, 32'h0000_5678, 5, 3, 3);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst data_rd", data_rd, 32'h0);
        chk("rst flags", {29'h0, active, done, error}, 32'h0);
        chk("rst cyc_stb_we", {29'h0, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o}, 32'h0);
        chk("rst adr", bus.wb_adr_o, 32'h0);
        chk("rst dat", bus.wb_dat_o, 32'h0);
        chk("rst sel", 32'(bus.wb_sel_o), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < nvec; i++) run_txn(vecs[i], i);

        // start held high: a new transfer begins from the IDLE cycle after DONE.
        @(negedge clk);
        address = 32'h9000_0000; selection = 4'hF; write = 1'b0; data_wr = 32'h0;
        cur_resp = R_ACK; start = 1'b1;
        @(negedge clk); chk("lvl stb1", 32'(bus.wb_stb_o), 32'd1);
        @(negedge clk); chk("lvl done1", 32'(done), 32'd1);
        @(negedge clk); chk("lvl idle", {30'h0, active, bus.wb_stb_o}, 32'h0);
        @(negedge clk); chk("lvl stb2", 32'(bus.wb_stb_o), 32'd1);
        start = 1'b0;
        @(negedge clk); chk("lvl done2", 32'(done), 32'd1);
        chk("lvl data_rd", data_rd, 32'hDEAD_BEEF);
        @(negedge clk); cur_resp = R_NONE;

        // Reset in the middle of a bus phase.
        @(negedge clk);
        address = 32'h9000_0004; write = 1'b1; data_wr = 32'h5555_AAAA; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("mid stb before rst", 32'(bus.wb_stb_o), 32'd1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid rst cyc_stb_we", {29'h0, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o}, 32'h0);
        chk("mid rst active", 32'(active), 32'd0);
        chk("mid rst adr_dat", bus.wb_adr_o | bus.wb_dat_o, 32'h0);
        chk("mid rst data_rd", data_rd, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int late = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (done || bus.wb_cyc_o || active) late++;
            end
            chk("mid rst no_done", 32'(late), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
